// File: rtl/ds1302_pkg.sv
// ============================================================================
//  Module      : ds1302_pkg
//  Description : Shared command bytes, register masks and sequencer state
//                encoding for the DS1302 time controller.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package ds1302_pkg;

    // Command bytes (write form; OR with RD_BIT for the read form)
    localparam logic [7:0] SEC_W     = 8'h80;
    localparam logic [7:0] MIN_W     = 8'h82;
    localparam logic [7:0] HOUR_W    = 8'h84;
    localparam logic [7:0] WP_W      = 8'h8E;
    localparam logic [7:0] WP_ON     = 8'h80;
    localparam logic [7:0] WP_OFF    = 8'h00;
    localparam logic [7:0] RD_BIT    = 8'h01;

    // Register masks: CH bit out of seconds, 12/24 h bits out of hours
    localparam logic [7:0] SEC_MASK  = 8'h7F;
    localparam logic [7:0] MIN_MASK  = 8'h7F;
    localparam logic [7:0] HOUR_MASK = 8'h3F;

    // Sequencer state encoding
    localparam logic [2:0] ST_WAIT     = 3'd0;
    localparam logic [2:0] ST_WR_ISSUE = 3'd1;
    localparam logic [2:0] ST_WR_ACK   = 3'd2;
    localparam logic [2:0] ST_RD_ISSUE = 3'd3;
    localparam logic [2:0] ST_RD_ACK   = 3'd4;
    localparam logic [2:0] ST_UPDATE   = 3'd5;

    typedef enum logic [2:0] {
        S_WAIT     = ST_WAIT,
        S_WR_ISSUE = ST_WR_ISSUE,
        S_WR_ACK   = ST_WR_ACK,
        S_RD_ISSUE = ST_RD_ISSUE,
        S_RD_ACK   = ST_RD_ACK,
        S_UPDATE   = ST_UPDATE
    } state_t;

    localparam logic [2:0] WR_LAST_STEP = 3'd4;
    localparam logic [2:0] RD_LAST_STEP = 3'd2;

    // Read command for a poll step: seconds, minutes, then hours
    function automatic logic [7:0] rd_cmd(input logic [2:0] step);
        case (step)
            3'd0:    rd_cmd = SEC_W  | RD_BIT;
            3'd1:    rd_cmd = MIN_W  | RD_BIT;
            default: rd_cmd = HOUR_W | RD_BIT;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ds1302_bcd_check.sv
// ============================================================================
//  Module      : ds1302_bcd_check
//  Description : Combinational validator for a BCD hh:mm:ss triple
//                (both nibbles 0-9, hour <= 23, minute/second <= 59).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ds1302_bcd_check (
    input  logic [7:0] i_hour,
    input  logic [7:0] i_min,
    input  logic [7:0] i_sec,
    output logic       o_valid
);

    // With both nibbles <= 9 a plain byte compare is a decimal compare
    function automatic logic field_ok(input logic [7:0] v, input logic [7:0] max_v);
        field_ok = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_v);
    endfunction

    assign o_valid = field_ok(i_hour, 8'h23) && field_ok(i_min, 8'h59) && field_ok(i_sec, 8'h59);

endmodule

`default_nettype wire

// File: rtl/ds1302_time_ctrl.sv
// ============================================================================
//  Module      : ds1302_time_ctrl
//  Description : Transaction sequencer ahead of the DS1302 byte converter.
//                Initialises the RTC, polls hh:mm:ss at a fixed interval and
//                services user set-time requests.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ds1302_time_ctrl
    import ds1302_pkg::*;
#(
    parameter int unsigned READ_INTERVAL = 25_000_000,
    parameter logic [7:0]  INIT_HOUR     = 8'h12,
    parameter logic [7:0]  INIT_MIN      = 8'h00,
    parameter logic [7:0]  INIT_SEC      = 8'h00
) (
    input  logic       ds1302_clk,
    input  logic       ds1302_rst_n,
    input  logic       set_req,
    input  logic [7:0] set_hour,
    input  logic [7:0] set_min,
    input  logic [7:0] set_sec,
    output logic       set_err,
    output logic [7:0] ds1302_write_addr,
    output logic [7:0] ds1302_write_data,
    output logic       ds1302_write_en,
    input  logic       ds1302_write_ack,
    output logic [7:0] ds1302_read_addr,
    input  logic [7:0] ds1302_read_data,
    output logic       ds1302_read_en,
    input  logic       ds1302_read_ack,
    output logic [7:0] time_hour,
    output logic [7:0] time_min,
    output logic [7:0] time_sec,
    output logic       time_valid,
    output logic       busy
);

    localparam int unsigned   CW       = (READ_INTERVAL > 1) ? $clog2(READ_INTERVAL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(READ_INTERVAL - 1);

    state_t        state_q, state_d;
    logic [2:0]    step_q, step_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic [7:0]    pend_hour_q, pend_hour_d, pend_min_q, pend_min_d, pend_sec_q, pend_sec_d;
    logic [7:0]    wr_hour_q, wr_hour_d, wr_min_q, wr_min_d, wr_sec_q, wr_sec_d;
    logic [7:0]    sh_hour_q, sh_hour_d, sh_min_q, sh_min_d, sh_sec_q, sh_sec_d;
    logic [7:0]    write_addr_q, write_addr_d, write_data_q, write_data_d;
    logic          write_en_q, write_en_d;
    logic [7:0]    read_addr_q, read_addr_d;
    logic          read_en_q, read_en_d;
    logic [7:0]    time_hour_q, time_hour_d, time_min_q, time_min_d, time_sec_q, time_sec_d;
    logic          time_valid_q, time_valid_d;
    logic          busy_q, busy_d;
    logic          set_err_q, set_err_d;
    logic          set_taken;
    logic          w_set_ok;

    ds1302_bcd_check u_bcd_check (
        .i_hour  (set_hour),
        .i_min   (set_min),
        .i_sec   (set_sec),
        .o_valid (w_set_ok)
    );

    // Next-state, converter handshake, poll capture and set-request latching
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        cnt_d        = '0;
        pend_d       = pend_q;
        pend_hour_d  = pend_hour_q;
        pend_min_d   = pend_min_q;
        pend_sec_d   = pend_sec_q;
        wr_hour_d    = wr_hour_q;
        wr_min_d     = wr_min_q;
        wr_sec_d     = wr_sec_q;
        sh_hour_d    = sh_hour_q;
        sh_min_d     = sh_min_q;
        sh_sec_d     = sh_sec_q;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        write_en_d   = write_en_q;
        read_addr_d  = read_addr_q;
        read_en_d    = read_en_q;
        time_hour_d  = time_hour_q;
        time_min_d   = time_min_q;
        time_sec_d   = time_sec_q;
        time_valid_d = 1'b0;
        set_err_d    = 1'b0;
        set_taken    = 1'b0;

        case (state_q)
            S_WAIT: begin
                if (pend_q) begin
                    // A valid request landing on the consuming cycle wins (last wins)
                    state_d = S_WR_ISSUE;
                    step_d  = 3'd0;
                    pend_d  = 1'b0;
                    if (set_req && w_set_ok) begin
                        set_taken = 1'b1;
                        wr_hour_d = set_hour;
                        wr_min_d  = set_min;
                        wr_sec_d  = set_sec;
                    end else begin
                        wr_hour_d = pend_hour_q;
                        wr_min_d  = pend_min_q;
                        wr_sec_d  = pend_sec_q;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_RD_ISSUE;
                    step_d  = 3'd0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WR_ISSUE: begin
                write_en_d = 1'b1;
                state_d    = S_WR_ACK;
                case (step_q)
                    3'd0: begin write_addr_d = WP_W;   write_data_d = WP_OFF;                end
                    3'd1: begin write_addr_d = HOUR_W; write_data_d = wr_hour_q & HOUR_MASK; end
                    3'd2: begin write_addr_d = MIN_W;  write_data_d = wr_min_q  & MIN_MASK;  end
                    3'd3: begin write_addr_d = SEC_W;  write_data_d = wr_sec_q  & SEC_MASK;  end
                    default: begin write_addr_d = WP_W; write_data_d = WP_ON;                end
                endcase
            end
            S_WR_ACK: begin
                if (ds1302_write_ack) begin
                    write_en_d = 1'b0;
                    if (step_q == WR_LAST_STEP) begin
                        state_d = S_RD_ISSUE;
                        step_d  = 3'd0;
                    end else begin
                        state_d = S_WR_ISSUE;
                        step_d  = step_q + 3'd1;
                    end
                end
            end
            S_RD_ISSUE: begin
                read_addr_d = rd_cmd(step_q);
                read_en_d   = 1'b1;
                state_d     = S_RD_ACK;
            end
            S_RD_ACK: begin
                if (ds1302_read_ack) begin
                    read_en_d = 1'b0;
                    case (step_q)
                        3'd0:    sh_sec_d  = ds1302_read_data & SEC_MASK;
                        3'd1:    sh_min_d  = ds1302_read_data & MIN_MASK;
                        default: sh_hour_d = ds1302_read_data & HOUR_MASK;
                    endcase
                    if (step_q == RD_LAST_STEP) begin
                        state_d = S_UPDATE;
                    end else begin
                        state_d = S_RD_ISSUE;
                        step_d  = step_q + 3'd1;
                    end
                end
            end
            S_UPDATE: begin
                time_hour_d  = sh_hour_q;
                time_min_d   = sh_min_q;
                time_sec_d   = sh_sec_q;
                time_valid_d = 1'b1;
                state_d      = S_WAIT;
            end
            default: begin
                state_d = S_WR_ISSUE;
                step_d  = 3'd0;
            end
        endcase

        if (set_req) begin
            if (!w_set_ok) begin
                set_err_d = 1'b1;
            end else if (!set_taken) begin
                pend_d      = 1'b1;
                pend_hour_d = set_hour;
                pend_min_d  = set_min;
                pend_sec_d  = set_sec;
            end
        end

        busy_d = (state_d == S_WR_ISSUE) || (state_d == S_WR_ACK);
    end

    // State and output registers; reset restarts the init write sequence
    always_ff @(posedge ds1302_clk or negedge ds1302_rst_n) begin
        if (!ds1302_rst_n) begin
            state_q      <= S_WR_ISSUE;
            step_q       <= 3'd0;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            pend_hour_q  <= 8'h00;
            pend_min_q   <= 8'h00;
            pend_sec_q   <= 8'h00;
            wr_hour_q    <= INIT_HOUR;
            wr_min_q     <= INIT_MIN;
            wr_sec_q     <= INIT_SEC;
            sh_hour_q    <= 8'h00;
            sh_min_q     <= 8'h00;
            sh_sec_q     <= 8'h00;
            write_addr_q <= 8'h00;
            write_data_q <= 8'h00;
            write_en_q   <= 1'b0;
            read_addr_q  <= 8'h00;
            read_en_q    <= 1'b0;
            time_hour_q  <= 8'h00;
            time_min_q   <= 8'h00;
            time_sec_q   <= 8'h00;
            time_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            set_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
            pend_hour_q  <= pend_hour_d;
            pend_min_q   <= pend_min_d;
            pend_sec_q   <= pend_sec_d;
            wr_hour_q    <= wr_hour_d;
            wr_min_q     <= wr_min_d;
            wr_sec_q     <= wr_sec_d;
            sh_hour_q    <= sh_hour_d;
            sh_min_q     <= sh_min_d;
            sh_sec_q     <= sh_sec_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            write_en_q   <= write_en_d;
            read_addr_q  <= read_addr_d;
            read_en_q    <= read_en_d;
            time_hour_q  <= time_hour_d;
            time_min_q   <= time_min_d;
            time_sec_q   <= time_sec_d;
            time_valid_q <= time_valid_d;
            busy_q       <= busy_d;
            set_err_q    <= set_err_d;
        end
    end

    assign ds1302_write_addr = write_addr_q;
    assign ds1302_write_data = write_data_q;
    assign ds1302_write_en   = write_en_q;
    assign ds1302_read_addr  = read_addr_q;
    assign ds1302_read_en    = read_en_q;
    assign time_hour         = time_hour_q;
    assign time_min          = time_min_q;
    assign time_sec          = time_sec_q;
    assign time_valid        = time_valid_q;
    assign busy              = busy_q;
    assign set_err           = set_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ds1302_time_ctrl.sv
// ============================================================================
//  Module      : tb_ds1302_time_ctrl
//  Description : Self-checking bench for ds1302_time_ctrl with a behavioural
//                converter + DS1302 register model.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ds1302_time_ctrl;

    localparam int unsigned RI     = 1000;
    localparam int          BUDGET = 20000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       set_req = 1'b0;
    logic [7:0] set_hour = 8'h00, set_min = 8'h00, set_sec = 8'h00;
    logic       set_err;
    logic [7:0] write_addr, write_data, read_addr;
    logic       write_en, read_en;
    logic       write_ack = 1'b0, read_ack = 1'b0;
    logic [7:0] read_data = 8'h00;
    logic [7:0] time_hour, time_min, time_sec;
    logic       time_valid, busy;

    always #5 clk = ~clk;

    ds1302_time_ctrl #(
        .READ_INTERVAL (RI),
        .INIT_HOUR     (8'h12),
        .INIT_MIN      (8'h00),
        .INIT_SEC      (8'h00)
    ) dut (
        .ds1302_clk        (clk),
        .ds1302_rst_n      (rst_n),
        .set_req           (set_req),
        .set_hour          (set_hour),
        .set_min           (set_min),
        .set_sec           (set_sec),
        .set_err           (set_err),
        .ds1302_write_addr (write_addr),
        .ds1302_write_data (write_data),
        .ds1302_write_en   (write_en),
        .ds1302_write_ack  (write_ack),
        .ds1302_read_addr  (read_addr),
        .ds1302_read_data  (read_data),
        .ds1302_read_en    (read_en),
        .ds1302_read_ack   (read_ack),
        .time_hour         (time_hour),
        .time_min          (time_min),
        .time_sec          (time_sec),
        .time_valid        (time_valid),
        .busy              (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- RTC + converter model ----------------
    logic [7:0]  rtc [0:7];
    logic        wp = 1'b1;
    int          ack_lat = 300;
    int          wcnt = 0, rcnt = 0;
    int          proto_viol = 0, busy_viol = 0;
    logic        wr_seen = 1'b0, rd_seen = 1'b0;
    logic [7:0]  held_waddr, held_wdata, held_raddr;
    logic [16:0] obs [$];
    logic [16:0] exp_q [$];

    always @(negedge clk) begin
        if (!rst_n) begin
            write_ack = 1'b0; read_ack = 1'b0;
            wcnt = 0; rcnt = 0; wr_seen = 1'b0; rd_seen = 1'b0;
        end else begin
            if (write_en && read_en) proto_viol++;
            if (write_en && !busy)   busy_viol++;
            if (read_en && busy)     busy_viol++;
            if (write_ack) begin
                write_ack = 1'b0;
            end else if (write_en) begin
                if (!wr_seen) begin
                    wr_seen = 1'b1; held_waddr = write_addr; held_wdata = write_data;
                end else if (write_addr !== held_waddr || write_data !== held_wdata) begin
                    proto_viol++;
                end
                if (wcnt >= ack_lat) begin
                    write_ack = 1'b1; wcnt = 0; wr_seen = 1'b0;
                    obs.push_back({1'b1, write_addr, write_data});
                    if (write_addr == 8'h8E)                  wp = write_data[7];
                    else if (!wp && write_addr[0] == 1'b0)    rtc[write_addr[3:1]] = write_data;
                end else begin
                    wcnt++;
                end
            end
            if (read_ack) begin
                read_ack = 1'b0;
            end else if (read_en) begin
                if (!rd_seen) begin
                    rd_seen = 1'b1; held_raddr = read_addr;
                end else if (read_addr !== held_raddr) begin
                    proto_viol++;
                end
                if (rcnt >= ack_lat) begin
                    read_ack = 1'b1; rcnt = 0; rd_seen = 1'b0;
                    read_data = rtc[read_addr[3:1]];
                    obs.push_back({1'b0, read_addr, 8'h00});
                end else begin
                    rcnt++;
                end
            end
        end
    end

    // ---------------- reference helpers ----------------
    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic bit field_ok(input logic [7:0] b, input int lim);
        int hi = int'(b[7:4]);
        int lo = int'(b[3:0]);
        return (hi <= 9) && (lo <= 9) && ((hi * 10 + lo) <= lim);
    endfunction

    task automatic exp_writes(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        exp_q.push_back({1'b1, 8'h8E, 8'h00});
        exp_q.push_back({1'b1, 8'h84, h});
        exp_q.push_back({1'b1, 8'h82, m});
        exp_q.push_back({1'b1, 8'h80, s});
        exp_q.push_back({1'b1, 8'h8E, 8'h80});
    endtask

    task automatic exp_reads();
        exp_q.push_back({1'b0, 8'h81, 8'h00});
        exp_q.push_back({1'b0, 8'h83, 8'h00});
        exp_q.push_back({1'b0, 8'h85, 8'h00});
    endtask

    task automatic check_log(input string tag);
        logic [16:0] e, o;
        check({tag, " count"}, obs.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs.size() > 0) ? obs.pop_front() : 17'h1FFFF;
            check({tag, " txn"}, o, e);
        end
        obs.delete();
    endtask

    task automatic wait_tv(input string tag);
        int n = 0;
        do begin @(negedge clk); n++; end while (time_valid !== 1'b1 && n < BUDGET);
        check({tag, " time_valid"}, time_valid, 1);
    endtask

    task automatic wait_rd(input string tag, output int cyc);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (read_en !== 1'b1 && cyc < BUDGET);
        check({tag, " read_en"}, read_en, 1);
    endtask

    task automatic check_time(input string tag, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        check({tag, " hour"}, time_hour, h);
        check({tag, " min"},  time_min,  m);
        check({tag, " sec"},  time_sec,  s);
    endtask

    // RTC contents as the display should see them (CH and 12/24h bits dropped)
    task automatic check_rtc_time(input string tag);
        check_time(tag, rtc[2] & 8'h3F, rtc[1] & 8'h7F, rtc[0] & 8'h7F);
    endtask

    task automatic pulse_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        set_hour = h; set_min = m; set_sec = s; set_req = 1'b1;
        @(negedge clk);
        set_req = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int gap;
        logic [7:0] h, m, s;
        for (int i = 0; i < 8; i++) rtc[i] = 8'($urandom);

        repeat (3) @(negedge clk);
        check("reset en",    {30'd0, write_en, read_en}, 0);
        check("reset flags", {29'd0, busy, time_valid, set_err}, 0);
        check("reset time",  {8'd0, time_hour, time_min, time_sec}, 0);
        check("reset addr",  {8'd0, write_addr, write_data, read_addr}, 0);

        // Init sequence with a slow converter
        exp_writes(8'h12, 8'h00, 8'h00);
        exp_reads();
        rst_n = 1'b1;
        wait_tv("init");
        check_log("init");
        check_time("init", 8'h12, 8'h00, 8'h00);

        // Polling at the fixed interval, random RTC contents with junk in masked bits
        for (int i = 0; i < 4; i++) begin
            ack_lat = $urandom_range(1, 8);
            rtc[0] = (i == 0) ? 8'hD9 : ({$urandom_range(0, 1) == 1, 7'd0} | to_bcd($urandom_range(0, 59)));
            rtc[1] = {$urandom_range(0, 1) == 1, 7'd0} | to_bcd($urandom_range(0, 59));
            rtc[2] = {2'($urandom_range(0, 3)), 6'd0} | to_bcd($urandom_range(0, 23));
            // poll start RI cycles after WAIT entry; read_en is registered one cycle later
            wait_rd("poll", gap);
            check("poll gap", gap, RI + 1);
            exp_reads();
            wait_tv("poll");
            check_log("poll");
            check_rtc_time("poll");
            if (i == 0) check("ch masked", time_sec, 8'h59);
        end

        // Set request arriving while a poll is in flight
        wait_rd("set mid", gap);
        pulse_set(8'h23, 8'h59, 8'h58);
        check("set ok err", set_err, 0);
        exp_reads();
        wait_tv("set mid poll");
        check_log("set mid poll");
        check_rtc_time("set mid poll");
        exp_writes(8'h23, 8'h59, 8'h58);
        exp_reads();
        wait_tv("set seq");
        check_log("set seq");
        check_time("set seq", 8'h23, 8'h59, 8'h58);
        rtc[0] = 8'h00; rtc[1] = 8'h00; rtc[2] = 8'h00;
        exp_reads();
        wait_tv("rollover");
        check_log("rollover");
        check_time("rollover", 8'h00, 8'h00, 8'h00);

        // Rejected requests: fixed cases then random invalid triples
        pulse_set(8'h12, 8'h30, 8'h5A);
        check("err sec 5A", set_err, 1);
        @(negedge clk);
        check("err one cycle", set_err, 0);
        pulse_set(8'h24, 8'h00, 8'h00);
        check("err hour 24", set_err, 1);
        for (int i = 0; i < 4; i++) begin
            do begin
                h = 8'($urandom); m = 8'($urandom); s = 8'($urandom);
            end while (field_ok(h, 23) && field_ok(m, 59) && field_ok(s, 59));
            @(negedge clk);
            pulse_set(h, m, s);
            check("err random", set_err, 1);
        end
        exp_reads();
        wait_tv("no write");
        check_log("no write");

        // Two accepted requests in the same WAIT: last one wins, single sequence
        pulse_set(8'h10, 8'h00, 8'h00);
        pulse_set(8'h11, 8'h11, 8'h11);
        check("double err", set_err, 0);
        exp_writes(8'h11, 8'h11, 8'h11);
        exp_reads();
        wait_tv("double");
        check_log("double");
        check_time("double", 8'h11, 8'h11, 8'h11);

        // Random valid requests
        for (int i = 0; i < 3; i++) begin
            ack_lat = $urandom_range(1, 6);
            h = to_bcd($urandom_range(0, 23));
            m = to_bcd($urandom_range(0, 59));
            s = to_bcd($urandom_range(0, 59));
            pulse_set(h, m, s);
            check("rand set err", set_err, 0);
            exp_writes(h, m, s);
            exp_reads();
            wait_tv("rand set");
            check_log("rand set");
            check_time("rand set", h, m, s);
        end

        // Reset asserted while a read request is outstanding
        wait_rd("rst mid", gap);
        #2 rst_n = 1'b0;
        #1;
        check("rst mid en",   {30'd0, write_en, read_en}, 0);
        check("rst mid busy", {31'd0, busy}, 0);
        check("rst mid time", {8'd0, time_hour, time_min, time_sec}, 0);
        check("rst mid addr", {24'd0, read_addr}, 0);
        obs.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_writes(8'h12, 8'h00, 8'h00);
        exp_reads();
        wait_tv("restart");
        check_log("restart");
        check_time("restart", 8'h12, 8'h00, 8'h00);

        check("protocol", proto_viol, 0);
        check("busy level", busy_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
